// File: rtl/eh2_lsu_dccm_bank_ctl_if.sv
// rtl/eh2_lsu_dccm_bank_ctl_if.sv - read/write bus between LSU and the banked DCCM controller
interface eh2_lsu_dccm_bank_ctl_if #(
    parameter int ADDR_BITS  = 13,
    parameter int DATA_WIDTH = 39
);
    logic                  rd_en;
    logic [ADDR_BITS-1:0]  rd_addr_lo;
    logic [ADDR_BITS-1:0]  rd_addr_hi;
    logic                  wr_en;
    logic                  wr_ready;
    logic [ADDR_BITS-1:0]  wr_addr_lo;
    logic [ADDR_BITS-1:0]  wr_addr_hi;
    logic [DATA_WIDTH-1:0] wr_data_lo;
    logic [DATA_WIDTH-1:0] wr_data_hi;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data_lo;
    logic [DATA_WIDTH-1:0] rd_data_hi;
    logic                  pend_valid;

    modport master (
        output rd_en, rd_addr_lo, rd_addr_hi,
        output wr_en, wr_addr_lo, wr_addr_hi, wr_data_lo, wr_data_hi,
        input  wr_ready, rd_valid, rd_data_lo, rd_data_hi, pend_valid
    );

    modport slave (
        input  rd_en, rd_addr_lo, rd_addr_hi,
        input  wr_en, wr_addr_lo, wr_addr_hi, wr_data_lo, wr_data_hi,
        output wr_ready, rd_valid, rd_data_lo, rd_data_hi, pend_valid
    );
endinterface

// File: rtl/eh2_lsu_dccm_bank_ctl.sv
// rtl/eh2_lsu_dccm_bank_ctl.sv - banked DCCM wrapper with one-entry pending write and read forwarding
module eh2_lsu_dccm_bank_ctl #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 512,
    parameter int DATA_WIDTH = 39,
    parameter int RD_LATENCY = 1,
    localparam int BANK_BITS  = $clog2(NUM_BANKS),
    localparam int INDEX_BITS = $clog2(BANK_DEPTH),
    localparam int ADDR_BITS  = 2 + BANK_BITS + INDEX_BITS,
    localparam int WORD_BITS  = ADDR_BITS - 2
) (
    input logic clk,
    input logic rst,
    eh2_lsu_dccm_bank_ctl_if.slave bus
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("eh2_lsu_dccm_bank_ctl: RD_LATENCY must be 1 or 2");
    end
    if (NUM_BANKS < 2 || NUM_BANKS > 8 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $error("eh2_lsu_dccm_bank_ctl: NUM_BANKS must be a power of 2 in 2..8");
    end
    if ((BANK_DEPTH & (BANK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("eh2_lsu_dccm_bank_ctl: BANK_DEPTH must be a power of 2");
    end

    // Word addresses carry bank in the low bits and index above it
    function automatic logic [BANK_BITS-1:0] bank_of(input logic [WORD_BITS-1:0] w);
        return w[0 +: BANK_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] index_of(input logic [WORD_BITS-1:0] w);
        return w[BANK_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [NUM_BANKS-1:0] bank_mask(input logic en,
                                                       input logic [WORD_BITS-1:0] lo,
                                                       input logic [WORD_BITS-1:0] hi);
        logic [NUM_BANKS-1:0] m;
        m = '0;
        if (en) begin
            m[bank_of(lo)] = 1'b1;
            m[bank_of(hi)] = 1'b1;
        end
        return m;
    endfunction

    // Byte offsets never select anything in a word-wide memory
    logic unused_byte_bits;
    assign unused_byte_bits = ^{bus.rd_addr_lo[1:0], bus.rd_addr_hi[1:0],
                                bus.wr_addr_lo[1:0], bus.wr_addr_hi[1:0]};

    logic [WORD_BITS-1:0] rd_word_lo, rd_word_hi, rd_word_hi_eff;
    logic [WORD_BITS-1:0] wr_word_lo, wr_word_hi;
    logic                 rd_unal, wr_unal;

    assign rd_word_lo     = bus.rd_addr_lo[ADDR_BITS-1:2];
    assign rd_word_hi     = bus.rd_addr_hi[ADDR_BITS-1:2];
    assign wr_word_lo     = bus.wr_addr_lo[ADDR_BITS-1:2];
    assign wr_word_hi     = bus.wr_addr_hi[ADDR_BITS-1:2];
    assign rd_unal        = bank_of(rd_word_lo) != bank_of(rd_word_hi);
    assign wr_unal        = bank_of(wr_word_lo) != bank_of(wr_word_hi);
    // An aligned access is a single word; the hi half mirrors the lo word
    assign rd_word_hi_eff = rd_unal ? rd_word_hi : rd_word_lo;

    // Pending write entry
    logic                  pend_valid;
    logic                  pend_unal;
    logic [WORD_BITS-1:0]  pend_word_lo, pend_word_hi;
    logic [DATA_WIDTH-1:0] pend_data_lo, pend_data_hi;

    logic [NUM_BANKS-1:0] rd_mask, wr_mask, pend_mask;
    logic                 wr_acc, wr_direct, drain;

    assign rd_mask   = bank_mask(bus.rd_en, rd_word_lo, rd_word_hi);
    assign wr_mask   = bank_mask(1'b1, wr_word_lo, wr_word_hi);
    assign pend_mask = bank_mask(1'b1, pend_word_lo, pend_word_hi);

    // Reads own the banks: a write only goes straight in when it avoids every read bank
    assign wr_acc    = bus.wr_en & ~pend_valid;
    assign wr_direct = wr_acc & ~|(wr_mask & rd_mask);
    assign drain     = pend_valid & ~|(pend_mask & rd_mask);

    assign bus.wr_ready   = ~pend_valid;
    assign bus.pend_valid = pend_valid;

    // Park a colliding write; retire the parked one once its banks are free of reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid   <= 1'b0;
            pend_unal    <= 1'b0;
            pend_word_lo <= '0;
            pend_word_hi <= '0;
            pend_data_lo <= '0;
            pend_data_hi <= '0;
        end else if (wr_acc && !wr_direct) begin
            pend_valid   <= 1'b1;
            pend_unal    <= wr_unal;
            pend_word_lo <= wr_word_lo;
            pend_word_hi <= wr_word_hi;
            pend_data_lo <= bus.wr_data_lo;
            pend_data_hi <= bus.wr_data_hi;
        end else if (drain) begin
            pend_valid   <= 1'b0;
        end
    end

    // Committing write: a direct write and a drain never coexist since acceptance needs an empty buffer
    logic                  commit;
    logic                  c_unal;
    logic [WORD_BITS-1:0]  c_word_lo, c_word_hi;
    logic [DATA_WIDTH-1:0] c_data_lo, c_data_hi;

    // Select the write that reaches the banks this cycle
    always_comb begin
        commit = wr_direct | drain;
        if (wr_direct) begin
            c_unal    = wr_unal;
            c_word_lo = wr_word_lo;
            c_word_hi = wr_word_hi;
            c_data_lo = bus.wr_data_lo;
            c_data_hi = bus.wr_data_hi;
        end else begin
            c_unal    = pend_unal;
            c_word_lo = pend_word_lo;
            c_word_hi = pend_word_hi;
            c_data_lo = pend_data_lo;
            c_data_hi = pend_data_hi;
        end
    end

    logic [NUM_BANKS-1:0]  bank_we, bank_re;
    logic [INDEX_BITS-1:0] bank_waddr [NUM_BANKS];
    logic [INDEX_BITS-1:0] bank_raddr [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_dout  [NUM_BANKS];

    // Steer lo/hi halves of the read and the committing write onto per-bank ports
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]    = 1'b0;
            bank_re[b]    = 1'b0;
            bank_waddr[b] = '0;
            bank_raddr[b] = '0;
            bank_wdata[b] = '0;
            if (commit && bank_of(c_word_lo) == BANK_BITS'(b)) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = index_of(c_word_lo);
                bank_wdata[b] = c_data_lo;
            end
            if (commit && c_unal && bank_of(c_word_hi) == BANK_BITS'(b)) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = index_of(c_word_hi);
                bank_wdata[b] = c_data_hi;
            end
            if (bus.rd_en && bank_of(rd_word_lo) == BANK_BITS'(b)) begin
                bank_re[b]    = 1'b1;
                bank_raddr[b] = index_of(rd_word_lo);
            end
            if (bus.rd_en && rd_unal && bank_of(rd_word_hi) == BANK_BITS'(b)) begin
                bank_re[b]    = 1'b1;
                bank_raddr[b] = index_of(rd_word_hi);
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] dout;

        // Storage array is deliberately left unreset
        always_ff @(posedge clk) begin
            if (bank_we[g]) begin
                mem[bank_waddr[g]] <= bank_wdata[g];
            end
        end

        // Synchronous read sees pre-write contents; dout holds between reads
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout <= '0;
            end else if (bank_re[g]) begin
                dout <= mem[bank_raddr[g]];
            end
        end

        assign bank_dout[g] = dout;
    end

    // Forwarding compare against the parked write, sampled with the read
    logic                  lo_hit_plo, lo_hit_phi, hi_hit_plo, hi_hit_phi;
    logic [DATA_WIDTH-1:0] fwd_data_lo, fwd_data_hi;

    assign lo_hit_plo  = pend_valid & (rd_word_lo == pend_word_lo);
    assign lo_hit_phi  = pend_valid & pend_unal & (rd_word_lo == pend_word_hi);
    assign hi_hit_plo  = pend_valid & (rd_word_hi_eff == pend_word_lo);
    assign hi_hit_phi  = pend_valid & pend_unal & (rd_word_hi_eff == pend_word_hi);
    assign fwd_data_lo = lo_hit_plo ? pend_data_lo : pend_data_hi;
    assign fwd_data_hi = hi_hit_plo ? pend_data_lo : pend_data_hi;

    logic                  s1_valid;
    logic [BANK_BITS-1:0]  s1_bank_lo, s1_bank_hi;
    logic                  s1_fwd_lo, s1_fwd_hi;
    logic [DATA_WIDTH-1:0] s1_fdata_lo, s1_fdata_hi;
    logic [DATA_WIDTH-1:0] s1_data_lo, s1_data_hi;

    // First read stage: remember which bank feeds each half and any forwarded data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_bank_lo  <= '0;
            s1_bank_hi  <= '0;
            s1_fwd_lo   <= 1'b0;
            s1_fwd_hi   <= 1'b0;
            s1_fdata_lo <= '0;
            s1_fdata_hi <= '0;
        end else begin
            s1_valid <= bus.rd_en;
            if (bus.rd_en) begin
                s1_bank_lo  <= bank_of(rd_word_lo);
                s1_bank_hi  <= bank_of(rd_word_hi_eff);
                s1_fwd_lo   <= lo_hit_plo | lo_hit_phi;
                s1_fwd_hi   <= hi_hit_plo | hi_hit_phi;
                s1_fdata_lo <= fwd_data_lo;
                s1_fdata_hi <= fwd_data_hi;
            end
        end
    end

    assign s1_data_lo = s1_fwd_lo ? s1_fdata_lo : bank_dout[s1_bank_lo];
    assign s1_data_hi = s1_fwd_hi ? s1_fdata_hi : bank_dout[s1_bank_hi];

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  out_valid;
        logic [DATA_WIDTH-1:0] out_data_lo, out_data_hi;

        // Output register stage for the two-cycle read
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid   <= 1'b0;
                out_data_lo <= '0;
                out_data_hi <= '0;
            end else begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_lo <= s1_data_lo;
                    out_data_hi <= s1_data_hi;
                end
            end
        end

        assign bus.rd_valid   = out_valid;
        assign bus.rd_data_lo = out_data_lo;
        assign bus.rd_data_hi = out_data_hi;
    end else begin : g_lat1
        // Stage-one state only changes on an accepted read, so the data holds otherwise
        assign bus.rd_valid   = s1_valid;
        assign bus.rd_data_lo = s1_data_lo;
        assign bus.rd_data_hi = s1_data_hi;
    end

endmodule
